alu_unit: RTL and testbench

- Execution stage directly downstream of the reservation station. It consumes one issued operation per cycle (op, operands, imm, pc, ROB tag).
- Computes the RV32I integer, jump and branch result. After a 1-cycle registered latency it broadcasts the result on the ALU CDB, which feeds the RS, LSB and ROB.
- Also reports branch/jump resolution (taken flag plus target) to the ROB for misprediction handling.

---
 rtl/alu_unit.sv | 174 +++++++++++++++++
 tb/tb_alu_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - RV32I integer/branch/jump execution unit with one-cycle registered CDB broadcast
//
// Purpose: takes one issued operation per cycle from the reservation station.
// It computes the integer, jump or branch result and broadcasts it on the ALU
// CDB one cycle later. It also reports control-transfer resolution (taken flag
// and next pc) to the ROB.
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-low reset
//   rdy              global ready; low holds every register
//   in_op            issued opcode (OP_NOP = no issue)
//   in_value1        rs1 value
//   in_value2        rs2 value
//   in_imm           sign-extended immediate
//   in_pc            instruction pc
//   in_rob_tag       destination ROB entry (0 = none)
//   in_rob_misbranch flush request from the ROB
//   out_cdb_tag      broadcast tag (0 = no broadcast)
//   out_cdb_value    result for rd
//   out_rob_jump     control transfer taken
//   out_rob_target   resolved next pc
module alu_unit #(
    parameter int DATA_W    = 32,
    parameter int ROB_TAG_W = 4,
    parameter int OP_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [OP_W-1:0]      in_op,
    input  logic [DATA_W-1:0]    in_value1,
    input  logic [DATA_W-1:0]    in_value2,
    input  logic [DATA_W-1:0]    in_imm,
    input  logic [DATA_W-1:0]    in_pc,
    input  logic [ROB_TAG_W-1:0] in_rob_tag,
    input  logic                 in_rob_misbranch,
    output logic [ROB_TAG_W-1:0] out_cdb_tag,
    output logic [DATA_W-1:0]    out_cdb_value,
    output logic                 out_rob_jump,
    output logic [DATA_W-1:0]    out_rob_target
);

    // Shared internal opcode encodings
    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(21);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(22);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(25);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(27);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(28);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(29);

    logic [ROB_TAG_W-1:0] tag_q,    tag_d;
    logic [DATA_W-1:0]    value_q,  value_d;
    logic                 jump_q,   jump_d;
    logic [DATA_W-1:0]    target_q, target_d;

    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] pc_plus_imm;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        shamt;
    logic              is_imm_form;
    logic              valid_op;
    logic              res_jump;
    logic [DATA_W-1:0] res_value;
    logic [DATA_W-1:0] res_target;

    assign pc_plus4    = in_pc + DATA_W'(4);
    assign pc_plus_imm = in_pc + in_imm;

    // The immediate ALU forms occupy the contiguous range ADDI..SRAI
    assign is_imm_form = (in_op >= OP_ADDI) && (in_op <= OP_SRAI);
    assign op_b        = is_imm_form ? in_imm : in_value2;
    assign shamt       = op_b[4:0];

    always_comb begin
        valid_op   = 1'b1;
        res_jump   = 1'b0;
        res_value  = '0;
        res_target = pc_plus4;
        case (in_op)
            OP_LUI:   res_value = in_imm;
            OP_AUIPC: res_value = pc_plus_imm;
            OP_JAL: begin
                res_value  = pc_plus4;
                res_jump   = 1'b1;
                res_target = pc_plus_imm;
            end
            OP_JALR: begin
                res_value  = pc_plus4;
                res_jump   = 1'b1;
                res_target = (in_value1 + in_imm) & ~DATA_W'(1);
            end
            OP_BEQ:  res_jump = (in_value1 == in_value2);
            OP_BNE:  res_jump = (in_value1 != in_value2);
            OP_BLT:  res_jump = ($signed(in_value1) <  $signed(in_value2));
            OP_BGE:  res_jump = ($signed(in_value1) >= $signed(in_value2));
            OP_BLTU: res_jump = (in_value1 <  in_value2);
            OP_BGEU: res_jump = (in_value1 >= in_value2);
            OP_ADD,  OP_ADDI:  res_value = in_value1 + op_b;
            OP_SUB:            res_value = in_value1 - op_b;
            OP_AND,  OP_ANDI:  res_value = in_value1 & op_b;
            OP_OR,   OP_ORI:   res_value = in_value1 | op_b;
            OP_XOR,  OP_XORI:  res_value = in_value1 ^ op_b;
            OP_SLL,  OP_SLLI:  res_value = in_value1 << shamt;
            OP_SRL,  OP_SRLI:  res_value = in_value1 >> shamt;
            OP_SRA,  OP_SRAI:  res_value = DATA_W'($signed(in_value1) >>> shamt);
            OP_SLT,  OP_SLTI:  res_value = DATA_W'($signed(in_value1) < $signed(op_b));
            OP_SLTU, OP_SLTIU: res_value = DATA_W'(in_value1 < op_b);
            default: valid_op = 1'b0;  // NOP and unknown opcodes
        endcase

        // Taken branches redirect to pc+imm; not-taken fall through to pc+4
        if ((in_op >= OP_BEQ) && (in_op <= OP_BGEU) && res_jump) begin
            res_target = pc_plus_imm;
        end
    end

    // Flush wins over issue; a missing op or tag 0 clears the broadcast.
    // Value and target are don't-care whenever the tag is 0, so they load freely.
    always_comb begin
        tag_d    = in_rob_tag;
        jump_d   = res_jump;
        value_d  = res_value;
        target_d = res_target;
        if (in_rob_misbranch || !valid_op || (in_rob_tag == '0)) begin
            tag_d  = '0;
            jump_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q    <= '0;
            value_q  <= '0;
            jump_q   <= 1'b0;
            target_q <= '0;
        end else if (rdy) begin
            tag_q    <= tag_d;
            value_q  <= value_d;
            jump_q   <= jump_d;
            target_q <= target_d;
        end
    end

    assign out_cdb_tag    = tag_q;
    assign out_cdb_value  = value_q;
    assign out_rob_jump   = jump_q;
    assign out_rob_target = target_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - directed self-checking bench for alu_unit
module tb_alu_unit;

    localparam logic [5:0] NOP  = 6'd0;
    localparam logic [5:0] LUI  = 6'd1;
    localparam logic [5:0] AUIPC = 6'd2;
    localparam logic [5:0] JAL  = 6'd3;
    localparam logic [5:0] JALR = 6'd4;
    localparam logic [5:0] BNE  = 6'd6;
    localparam logic [5:0] BLT  = 6'd7;
    localparam logic [5:0] BGE  = 6'd8;
    localparam logic [5:0] BLTU = 6'd9;
    localparam logic [5:0] SLTI = 6'd12;
    localparam logic [5:0] SLLI = 6'd17;
    localparam logic [5:0] SRAI = 6'd19;
    localparam logic [5:0] ADD  = 6'd20;
    localparam logic [5:0] SUB  = 6'd21;
    localparam logic [5:0] SLT  = 6'd23;
    localparam logic [5:0] SLTU = 6'd24;
    localparam logic [5:0] SRA  = 6'd27;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [5:0]  in_op;
    logic [31:0] in_value1;
    logic [31:0] in_value2;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic [3:0]  in_rob_tag;
    logic        in_rob_misbranch;
    logic [3:0]  out_cdb_tag;
    logic [31:0] out_cdb_value;
    logic        out_rob_jump;
    logic [31:0] out_rob_target;

    int n_tests;
    int n_fail;

    alu_unit dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .in_op            (in_op),
        .in_value1        (in_value1),
        .in_value2        (in_value2),
        .in_imm           (in_imm),
        .in_pc            (in_pc),
        .in_rob_tag       (in_rob_tag),
        .in_rob_misbranch (in_rob_misbranch),
        .out_cdb_tag      (out_cdb_tag),
        .out_cdb_value    (out_cdb_value),
        .out_rob_jump     (out_rob_jump),
        .out_rob_target   (out_rob_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one op, then sample outputs 1 time unit after the capturing edge
    task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        in_op      = op;
        in_value1  = v1;
        in_value2  = v2;
        in_imm     = imm;
        in_pc      = pc;
        in_rob_tag = tag;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] tag, input logic [31:0] value,
                              input logic jump, input logic [31:0] target);
        check({name, ".tag"},    32'(out_cdb_tag),    32'(tag));
        check({name, ".value"},  out_cdb_value,       value);
        check({name, ".jump"},   32'(out_rob_jump),   32'(jump));
        check({name, ".target"}, out_rob_target,      target);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        rdy = 1'b1;
        in_rob_misbranch = 1'b0;
        in_op = NOP; in_value1 = '0; in_value2 = '0; in_imm = '0; in_pc = '0; in_rob_tag = '0;

        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 4'd0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;

        // Broadcast tag 5, then assert reset between edges
        issue(ADD, 32'd1, 32'd2, 32'd0, 32'h10, 4'd5);
        check("pre_reset.tag", 32'(out_cdb_tag), 32'd5);
        #1 rst = 1'b0;
        #1;
        expect_out("async_reset", 4'd0, 32'h0, 1'b0, 32'h0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        issue(ADD, 32'h7FFFFFFF, 32'd1, 32'd0, 32'h200, 4'd3);
        expect_out("add", 4'd3, 32'h80000000, 1'b0, 32'h204);
        issue(SRA, 32'h80000000, 32'h21, 32'd0, 32'h204, 4'd4);
        expect_out("sra", 4'd4, 32'hC0000000, 1'b0, 32'h208);

        issue(SLT, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 4'd1);
        check("slt", out_cdb_value, 32'd1);
        issue(SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 4'd1);
        check("sltu", out_cdb_value, 32'd0);
        issue(SLTI, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h0, 4'd1);
        check("slti", out_cdb_value, 32'd0);

        issue(BLT, 32'hFFFFFFFE, 32'd3, 32'h20, 32'h100, 4'd7);
        expect_out("blt", 4'd7, 32'h0, 1'b1, 32'h120);
        issue(BGE, 32'hFFFFFFFE, 32'd3, 32'h20, 32'h100, 4'd7);
        expect_out("bge", 4'd7, 32'h0, 1'b0, 32'h104);
        issue(BLTU, 32'hFFFFFFFE, 32'd3, 32'h20, 32'h100, 4'd8);
        check("bltu.jump", 32'(out_rob_jump), 32'd0);
        issue(BNE, 32'd9, 32'd9, 32'h20, 32'h100, 4'd8);
        check("bne_eq.jump", 32'(out_rob_jump), 32'd0);

        issue(JALR, 32'h1003, 32'd0, 32'd4, 32'h40, 4'd2);
        expect_out("jalr", 4'd2, 32'h44, 1'b1, 32'h1006);
        issue(JAL, 32'd0, 32'd0, 32'h10, 32'h40, 4'd2);
        expect_out("jal", 4'd2, 32'h44, 1'b1, 32'h50);

        issue(SUB, 32'd5, 32'd7, 32'd0, 32'h0, 4'd9);
        check("sub", out_cdb_value, 32'hFFFFFFFE);
        issue(SLLI, 32'd1, 32'hFFFFFFFF, 32'h23, 32'h0, 4'd9);
        check("slli", out_cdb_value, 32'd8);
        issue(SRAI, 32'h80000000, 32'd0, 32'd4, 32'h0, 4'd9);
        check("srai", out_cdb_value, 32'hF8000000);
        issue(LUI, 32'd0, 32'd0, 32'h12345000, 32'h0, 4'd9);
        check("lui", out_cdb_value, 32'h12345000);
        issue(AUIPC, 32'd0, 32'd0, 32'h2000, 32'h1000, 4'd9);
        check("auipc", out_cdb_value, 32'h3000);

        issue(ADD, 32'd1, 32'd1, 32'd0, 32'h0, 4'd0);
        check("tag0.tag", 32'(out_cdb_tag), 32'd0);
        issue(JAL, 32'd0, 32'd0, 32'h10, 32'h0, 4'd0);
        check("tag0.jump", 32'(out_rob_jump), 32'd0);
        issue(6'd63, 32'd1, 32'd1, 32'd0, 32'h0, 4'd5);
        check("unknown.tag", 32'(out_cdb_tag), 32'd0);

        in_rob_misbranch = 1'b1;
        issue(ADD, 32'd1, 32'd1, 32'd0, 32'h0, 4'd2);
        check("flush.tag", 32'(out_cdb_tag), 32'd0);
        issue(JAL, 32'd0, 32'd0, 32'h10, 32'h0, 4'd2);
        check("flush.jump", 32'(out_rob_jump), 32'd0);
        in_rob_misbranch = 1'b0;

        issue(ADD, 32'd10, 32'd20, 32'd0, 32'h0, 4'd6);
        check("stall_pre.tag", 32'(out_cdb_tag), 32'd6);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(ADD, 32'd100, 32'd1, 32'd0, 32'h0, 4'd9);
            check($sformatf("stall%0d.tag", i), 32'(out_cdb_tag), 32'd6);
            check($sformatf("stall%0d.value", i), out_cdb_value, 32'd30);
        end
        rdy = 1'b1;
        issue(NOP, 32'd0, 32'd0, 32'd0, 32'h0, 4'd0);
        check("post_stall_nop.tag", 32'(out_cdb_tag), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
